// File: rtl/overlay_corner_ctrl.sv
// Per-frame corner collector and overlay address-update controller.
// Validates four detected corners per frame and commits them to the overlay generator.
module overlay_corner_ctrl #(
  parameter int unsigned MISS_LIMIT = 4,
  parameter int unsigned ROWS       = 600,
  parameter int unsigned COLS       = 800
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_corner_valid,
  input  logic [1:0]  i_corner_id,
  input  logic [19:0] i_corner_addr,
  input  logic        i_user_enable,
  output logic        o_addr_valid,
  output logic [19:0] o_ul_addr,
  output logic [19:0] o_ur_addr,
  output logic [19:0] o_dl_addr,
  output logic [19:0] o_dr_addr,
  output logic        o_enable,
  output logic        o_locked,
  output logic [3:0]  o_miss_cnt
);

  localparam int unsigned AW = 20;
  localparam int unsigned CW = 10;
  localparam int unsigned MW = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_LOST  = 2'd2;

  logic [1:0]    state, state_next;
  logic [AW-1:0] shadow [4];
  logic [3:0]    mask, mask_next;
  logic          corner_ok, frame_good;

  logic          addr_valid_next, enable_next, locked_next;
  logic [AW-1:0] ul_next, ur_next, dl_next, dr_next;
  logic [MW-1:0] miss_next, miss_inc;

  assign corner_ok = i_corner_valid
                   && (32'(i_corner_addr[19:10]) < ROWS)
                   && (32'(i_corner_addr[9:0])   < COLS);

  // Shadow set as it stood before this cycle; strict ordering on rows and columns.
  assign frame_good = (mask == 4'hF)
                    && (shadow[0][19:10] < shadow[2][19:10])
                    && (shadow[1][19:10] < shadow[3][19:10])
                    && (shadow[0][CW-1:0] < shadow[1][CW-1:0])
                    && (shadow[2][CW-1:0] < shadow[3][CW-1:0]);

  assign miss_inc = o_miss_cnt + MW'(1);

  // A corner arriving with the frame start lands in the freshly cleared set.
  always_comb begin
    mask_next = i_frame_start ? 4'h0 : mask;
    if (corner_ok) mask_next[i_corner_id] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
      mask <= '0;
    end else begin
      if (corner_ok) shadow[i_corner_id] <= i_corner_addr;
      mask <= mask_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next      = state;
    addr_valid_next = 1'b0;
    enable_next     = o_enable;
    ul_next         = o_ul_addr;
    ur_next         = o_ur_addr;
    dl_next         = o_dl_addr;
    dr_next         = o_dr_addr;
    miss_next       = o_miss_cnt;
    if (i_frame_start) begin
      case (state)
        S_IDLE: state_next = S_LOST;
        S_LOST, S_TRACK: begin
          if (frame_good) begin
            state_next      = S_TRACK;
            addr_valid_next = 1'b1;
            enable_next     = i_user_enable;
            ul_next         = shadow[0];
            ur_next         = shadow[1];
            dl_next         = shadow[2];
            dr_next         = shadow[3];
            miss_next       = '0;
          end else if (state == S_TRACK) begin
            miss_next = miss_inc;
            // Single disable pulse on the frame that exhausts the miss budget.
            if (miss_inc == MW'(MISS_LIMIT)) begin
              state_next      = S_LOST;
              addr_valid_next = 1'b1;
              enable_next     = 1'b0;
            end
          end else if (o_miss_cnt < MW'(MISS_LIMIT)) begin
            miss_next = miss_inc;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
    locked_next = (state_next == S_TRACK);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_addr_valid <= 1'b0;
      o_enable     <= 1'b0;
      o_locked     <= 1'b0;
      o_miss_cnt   <= '0;
      o_ul_addr    <= '0;
      o_ur_addr    <= '0;
      o_dl_addr    <= '0;
      o_dr_addr    <= '0;
    end else begin
      o_addr_valid <= addr_valid_next;
      o_enable     <= enable_next;
      o_locked     <= locked_next;
      o_miss_cnt   <= miss_next;
      o_ul_addr    <= ul_next;
      o_ur_addr    <= ur_next;
      o_dl_addr    <= dl_next;
      o_dr_addr    <= dr_next;
    end
  end

endmodule

// File: tb/tb_overlay_corner_ctrl.sv
// Scoreboard bench for overlay_corner_ctrl: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_overlay_corner_ctrl;

  localparam int unsigned LIM = 4;
  localparam int unsigned NR  = 600;
  localparam int unsigned NC  = 800;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_corner_valid = 1'b0;
  logic [1:0]  i_corner_id = 2'd0;
  logic [19:0] i_corner_addr = 20'd0;
  logic        i_user_enable = 1'b0;
  logic        o_addr_valid, o_enable, o_locked;
  logic [19:0] o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr;
  logic [3:0]  o_miss_cnt;

  overlay_corner_ctrl #(.MISS_LIMIT(LIM), .ROWS(NR), .COLS(NC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .i_corner_valid(i_corner_valid), .i_corner_id(i_corner_id),
    .i_corner_addr(i_corner_addr), .i_user_enable(i_user_enable),
    .o_addr_valid(o_addr_valid), .o_ul_addr(o_ul_addr), .o_ur_addr(o_ur_addr),
    .o_dl_addr(o_dl_addr), .o_dr_addr(o_dr_addr), .o_enable(o_enable),
    .o_locked(o_locked), .o_miss_cnt(o_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        en;
    logic        locked;
    logic [3:0]  miss;
    logic [19:0] ul, ur, dl, dr;
  } pulse_t;

  pulse_t      exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_on = 1'b0;

  // Reference model: mode 0 = before first frame, 1 = searching, 2 = locked.
  int          m_mode;
  int          m_miss;
  bit          m_en;
  logic [19:0] m_sh  [4];
  bit          m_seen[4];
  logic [19:0] m_out [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit geometry_ok();
    int ur, uc, rr, rc, lr, lc, dr, dc;
    ur = int'(m_sh[0][19:10]); uc = int'(m_sh[0][9:0]);
    rr = int'(m_sh[1][19:10]); rc = int'(m_sh[1][9:0]);
    lr = int'(m_sh[2][19:10]); lc = int'(m_sh[2][9:0]);
    dr = int'(m_sh[3][19:10]); dc = int'(m_sh[3][9:0]);
    return m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]
        && ur < lr && rr < dr && uc < rc && lc < dc;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_miss = 0; m_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = '0; m_seen[i] = 1'b0; m_out[i] = '0;
    end
    exp_q.delete();
  endtask

  // Applied at each rising edge using the inputs presented for that edge.
  task automatic model_step();
    pulse_t p;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    if (i_frame_start) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (geometry_ok()) begin
        for (int i = 0; i < 4; i++) m_out[i] = m_sh[i];
        m_en = i_user_enable; m_miss = 0; m_mode = 2;
        p = '{en: m_en, locked: 1'b1, miss: 4'd0,
              ul: m_out[0], ur: m_out[1], dl: m_out[2], dr: m_out[3]};
        exp_q.push_back(p);
      end else if (m_mode == 2) begin
        m_miss++;
        if (m_miss == int'(LIM)) begin
          m_en = 1'b0; m_mode = 1;
          p = '{en: 1'b0, locked: 1'b0, miss: 4'(m_miss),
                ul: m_out[0], ur: m_out[1], dl: m_out[2], dr: m_out[3]};
          exp_q.push_back(p);
        end
      end else if (m_miss < int'(LIM)) begin
        m_miss++;
      end
      for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    end
    if (i_corner_valid && int'(i_corner_addr[19:10]) < int'(NR)
        && int'(i_corner_addr[9:0]) < int'(NC)) begin
      m_sh[i_corner_id] = i_corner_addr;
      m_seen[i_corner_id] = 1'b1;
    end
  endtask

  // Monitor: pulse presence and payload from the queue, levels from the model.
  always @(negedge i_clk) begin
    if (mon_on) begin
      pulse_t p;
      chk("addr_valid", 32'(o_addr_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        if (o_addr_valid) begin
          chk("pulse_enable", 32'(o_enable), 32'(p.en));
          chk("pulse_locked", 32'(o_locked), 32'(p.locked));
          chk("pulse_miss", 32'(o_miss_cnt), 32'(p.miss));
          chk("pulse_ul", 32'(o_ul_addr), 32'(p.ul));
          chk("pulse_ur", 32'(o_ur_addr), 32'(p.ur));
          chk("pulse_dl", 32'(o_dl_addr), 32'(p.dl));
          chk("pulse_dr", 32'(o_dr_addr), 32'(p.dr));
        end
      end
      chk("locked", 32'(o_locked), 32'(m_mode == 2));
      chk("miss_cnt", 32'(o_miss_cnt), 32'(m_miss));
      chk("enable", 32'(o_enable), 32'(m_en));
      chk("corners", {12'd0, o_ul_addr ^ o_ur_addr ^ o_dl_addr ^ o_dr_addr},
          {12'd0, m_out[0] ^ m_out[1] ^ m_out[2] ^ m_out[3]});
      chk("ul_level", 32'(o_ul_addr), 32'(m_out[0]));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    i_frame_start = 1'b0;
    i_corner_valid = 1'b0;
  endtask

  task automatic corner(input int id, input int row, input int col);
    i_corner_valid = 1'b1;
    i_corner_id = 2'(id);
    i_corner_addr = {10'(row), 10'(col)};
    tick();
  endtask

  task automatic frame(input bit ue);
    i_frame_start = 1'b1;
    i_user_enable = ue;
    tick();
  endtask

  task automatic square(input int r0, input int c0, input int r1, input int c1);
    corner(0, r0, c0); corner(1, r0, c1); corner(2, r1, c0); corner(3, r1, c1);
  endtask

  initial begin
    int r0, r1, c0, c1, row, col, id, start, kind;
    model_reset();
    i_rst_n = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    mon_on = 1'b1;
    chk("reset_ul", 32'(o_ul_addr), 32'd0);
    chk("reset_locked", 32'(o_locked), 32'd0);

    // Initial lock on the reference square.
    frame(1'b1);
    chk("idle_no_pulse", 32'(o_addr_valid), 32'd0);
    square(100, 100, 300, 300);
    frame(1'b1);
    chk("tp1_valid", 32'(o_addr_valid), 32'd1);
    chk("tp1_enable", 32'(o_enable), 32'd1);
    chk("tp1_ul", 32'(o_ul_addr), 32'h19064);
    chk("tp1_locked", 32'(o_locked), 32'd1);
    tick();
    chk("tp1_one_cycle", 32'(o_addr_valid), 32'd0);

    // Four short frames drop the overlay once; the fifth is silent.
    for (int f = 1; f <= 5; f++) begin
      corner(0, 10, 10); corner(1, 10, 50); corner(2, 60, 10);
      frame(1'b1);
      if (f < 4) begin
        chk("tp2_miss", 32'(o_miss_cnt), 32'(f));
        chk("tp2_nopulse", 32'(o_addr_valid), 32'd0);
      end else if (f == 4) begin
        chk("tp2_drop_valid", 32'(o_addr_valid), 32'd1);
        chk("tp2_drop_enable", 32'(o_enable), 32'd0);
        chk("tp2_drop_ul", 32'(o_ul_addr), 32'h19064);
        chk("tp2_drop_locked", 32'(o_locked), 32'd0);
      end else begin
        chk("tp2_no_repeat", 32'(o_addr_valid), 32'd0);
      end
    end

    // Out-of-range corners are rejected even with all ids present.
    square(20, 20, 40, 40); frame(1'b1);
    corner(0, 10, 10); corner(1, 10, 90); corner(2, 50, 10); corner(3, 600, 90);
    frame(1'b1);
    chk("tp3_row_reject", 32'(o_miss_cnt), 32'd1);
    corner(0, 10, 10); corner(1, 10, 800); corner(2, 50, 10); corner(3, 50, 90);
    frame(1'b1);
    chk("tp3_col_reject", 32'(o_miss_cnt), 32'd2);

    // Equal columns fail geometry.
    corner(0, 10, 200); corner(1, 10, 200); corner(2, 50, 10); corner(3, 50, 300);
    frame(1'b1);
    chk("tp4_equal_col", 32'(o_addr_valid), 32'd0);

    // Last write wins; same-cycle corner joins the next frame.
    corner(0, 50, 50); corner(0, 120, 120);
    corner(1, 120, 300); corner(2, 300, 120); corner(3, 300, 300);
    i_corner_valid = 1'b1; i_corner_id = 2'd0; i_corner_addr = {10'd120, 10'd120};
    frame(1'b0);
    chk("tp5_dup_ul", 32'(o_ul_addr), {12'd0, 10'd120, 10'd120});
    chk("tp5_enable", 32'(o_enable), 32'd0);
    corner(1, 120, 300); corner(2, 300, 120); corner(3, 300, 300);
    frame(1'b1);
    chk("tp5_carry_commit", 32'(o_addr_valid), 32'd1);

    // Reset mid-frame returns to the pre-frame state.
    corner(0, 1, 1); corner(1, 1, 5); corner(2, 5, 1);
    i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
    chk("tp6_ul", 32'(o_ul_addr), 32'd0);
    chk("tp6_enable", 32'(o_enable), 32'd0);
    chk("tp6_miss", 32'(o_miss_cnt), 32'd0);
    corner(3, 5, 5);
    frame(1'b1);
    chk("tp6_no_pulse", 32'(o_addr_valid), 32'd0);

    // Randomized frames.
    for (int f = 0; f < 300; f++) begin
      r0 = int'($urandom_range(0, 590)); r1 = int'($urandom_range(r0 + 1, 599));
      c0 = int'($urandom_range(0, 790)); c1 = int'($urandom_range(c0 + 1, 799));
      start = int'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        id = (start + k) % 4;
        row = id[1] ? r1 : r0;
        col = id[0] ? c1 : c0;
        kind = int'($urandom_range(0, 24));
        if (kind == 1) row = int'($urandom_range(NR, 1023));
        if (kind == 2) col = int'($urandom_range(NC, 1023));
        if (kind == 3) row = id[1] ? r0 : r1;
        if ($urandom_range(0, 7) == 0)
          corner(id, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        if (kind != 0) corner(id, row, col);
        repeat ($urandom_range(0, 2)) tick();
      end
      if ($urandom_range(0, 39) == 0) begin
        i_rst_n = 1'b0; tick(); i_rst_n = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) begin
        i_corner_valid = 1'b1;
        i_corner_id = 2'($urandom_range(0, 3));
        i_corner_addr = 20'($urandom);
      end
      frame(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) frame(1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
